// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/exception sequencer.
// Pure definitions: no latency and no backpressure of its own.
// Holds FSM states, SIIC/RTI opcodes, pc_sel codes, fixed vectors and the control bundle.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_EXC     = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    localparam logic [4:0] OP_SIIC = 5'b00010;
    localparam logic [4:0] OP_RTI  = 5'b00011;

    localparam logic [1:0] PCSEL_SEQ = 2'b00;
    localparam logic [1:0] PCSEL_BR  = 2'b01;
    localparam logic [1:0] PCSEL_EXC = 2'b10;
    localparam logic [1:0] PCSEL_EPC = 2'b11;

    localparam logic [15:0] EXC_VECTOR = 16'h0002;
    localparam logic [15:0] NOP_INSTR  = 16'h0800;

    localparam int REG_W = 3;
    localparam int CNT_W = 3;

    typedef struct packed {
        logic       stall_fetch;
        logic       stall_decode;
        logic       stall_ex;
        logic       flush_ifid;
        logic       flush_idex;
        logic [1:0] pc_sel;
        logic       halted;
    } ctrl_t;

    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c        = '0;
        c.pc_sel = PCSEL_SEQ;
        return c;
    endfunction

    function automatic logic is_exc_op(input logic [4:0] op);
        return (op == OP_SIIC) || (op == OP_RTI);
    endfunction

endpackage

// File: rtl/pipe_raw_detect.sv
// Register-match comparator for one producing pipe stage (rs/rt against its destination).
// Latency: purely combinational.
// Backpressure: none; consumers decide whether a hit stalls.
module pipe_raw_detect
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int RW = REG_W
) (
    input  logic [RW-1:0] rs,
    input  logic [RW-1:0] rt,
    input  logic          rs_vld,
    input  logic          rt_vld,
    input  logic [RW-1:0] write_sel,
    input  logic          reg_write,
    output logic          rs_hit,
    output logic          rt_hit
);

    assign rs_hit = reg_write & rs_vld & (rs == write_sel);
    assign rt_hit = reg_write & rt_vld & (rt == write_sel);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/redirect sequencer for IF/ID, ID/EX, EX/MEM; runs the SIIC/RTI exception sequence.
// Latency: outputs combinational from state and inputs; state/cnt/epc update on the clock edge.
// Backpressure: dmem_stall freezes the whole pipe; imem_stall holds fetch. Macro PIPE_FWD_EN.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2,
    parameter int PC_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       id_rs,
    input  logic [2:0]       id_rt,
    input  logic             id_rs_vld,
    input  logic             id_rt_vld,
    input  logic [2:0]       ex_write_sel,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [2:0]       mem_write_sel,
    input  logic             mem_reg_write,
    input  logic [4:0]       ex_opcode,
    input  logic [PC_W-1:0]  ex_pc_next,
    input  logic             ex_br_taken,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    input  logic             wb_halt,
    output logic             stall_fetch,
    output logic             stall_decode,
    output logic             stall_ex,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic [1:0]       pc_sel,
    output logic [PC_W-1:0]  epc,
    output logic             halted
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    ctrl_t              ctrl;
    logic               take_siic;

    logic ex_rs_hit, ex_rt_hit;
    logic ex_hit, load_use, raw_hazard;

    pipe_raw_detect #(.RW(REG_W)) u_ex_detect (
        .rs        (id_rs),
        .rt        (id_rt),
        .rs_vld    (id_rs_vld),
        .rt_vld    (id_rt_vld),
        .write_sel (ex_write_sel),
        .reg_write (ex_reg_write),
        .rs_hit    (ex_rs_hit),
        .rt_hit    (ex_rt_hit)
    );

    assign ex_hit   = ex_rs_hit | ex_rt_hit;
    assign load_use = ex_hit & ex_mem_read;

`ifdef PIPE_FWD_EN
    // Forwarding covers every ALU result; only a load's data arrives too late.
    logic unused_mem;
    assign unused_mem = ^{mem_write_sel, mem_reg_write};
    assign raw_hazard = load_use;
`else
    logic mem_rs_hit, mem_rt_hit;

    pipe_raw_detect #(.RW(REG_W)) u_mem_detect (
        .rs        (id_rs),
        .rt        (id_rt),
        .rs_vld    (id_rs_vld),
        .rt_vld    (id_rt_vld),
        .write_sel (mem_write_sel),
        .reg_write (mem_reg_write),
        .rs_hit    (mem_rs_hit),
        .rt_hit    (mem_rt_hit)
    );

    // No bypass paths: wait until the producer has left MEM. load_use is a subset of ex_hit.
    assign raw_hazard = load_use | ex_hit | mem_rs_hit | mem_rt_hit;
`endif

    // MEMWAIT behaves like RUN once dmem_stall drops, so the frozen EX instruction is serviced.
    always_comb begin
        ctrl      = ctrl_idle();
        take_siic = 1'b0;
        if (state == ST_HALT || wb_halt) begin
            ctrl.stall_fetch = 1'b1;
            ctrl.halted      = 1'b1;
        end else if (dmem_stall) begin
            ctrl.stall_fetch  = 1'b1;
            ctrl.stall_decode = 1'b1;
            ctrl.stall_ex     = 1'b1;
        end else if (state == ST_EXC) begin
            ctrl.stall_fetch = 1'b1;
        end else if (is_exc_op(ex_opcode)) begin
            ctrl.flush_ifid = 1'b1;
            ctrl.flush_idex = 1'b1;
            if (ex_opcode == OP_SIIC) begin
                ctrl.pc_sel = PCSEL_EXC;
                take_siic   = 1'b1;
            end else begin
                ctrl.pc_sel = PCSEL_EPC;
            end
        end else if (ex_br_taken) begin
            ctrl.flush_ifid = 1'b1;
            ctrl.flush_idex = 1'b1;
            ctrl.pc_sel     = PCSEL_BR;
        end else if (raw_hazard) begin
            ctrl.stall_fetch  = 1'b1;
            ctrl.stall_decode = 1'b1;
        end else if (imem_stall) begin
            ctrl.stall_fetch = 1'b1;
            ctrl.flush_ifid  = 1'b1;
        end
    end

    assign stall_fetch  = ctrl.stall_fetch;
    assign stall_decode = ctrl.stall_decode;
    assign stall_ex     = ctrl.stall_ex;
    assign flush_ifid   = ctrl.flush_ifid;
    assign flush_idex   = ctrl.flush_idex;
    assign pc_sel       = ctrl.pc_sel;
    assign halted       = ctrl.halted;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RUN;
            cnt   <= '0;
            epc   <= '0;
        end else if (state == ST_HALT || wb_halt) begin
            state <= ST_HALT;
        end else if (dmem_stall) begin
            // Drain count is frozen while memory is busy; EXC is not abandoned.
            if (state != ST_EXC) begin
                state <= ST_MEMWAIT;
            end
        end else if (state == ST_EXC) begin
            if (cnt <= CNT_W'(1)) begin
                state <= ST_RUN;
                cnt   <= '0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end else if (take_siic) begin
            state <= ST_EXC;
            cnt   <= CNT_W'(DRAIN_CYCLES);
            epc   <= ex_pc_next;
        end else begin
            state <= ST_RUN;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: driver pushes model expectations, monitor compares.
// Expectations come from a rule-level model (halt flag, drain countdown, saved EPC).
module tb_pipe_hazard_ctrl;

    localparam int DRAIN = 2;
    localparam int PCW   = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      id_rs, id_rt, ex_write_sel, mem_write_sel;
    logic            id_rs_vld, id_rt_vld, ex_reg_write, ex_mem_read, mem_reg_write;
    logic [4:0]      ex_opcode;
    logic [PCW-1:0]  ex_pc_next, epc;
    logic            ex_br_taken, imem_stall, dmem_stall, wb_halt;
    logic            stall_fetch, stall_decode, stall_ex, flush_ifid, flush_idex, halted;
    logic [1:0]      pc_sel;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .PC_W(PCW)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_vld(id_rs_vld), .id_rt_vld(id_rt_vld),
        .ex_write_sel(ex_write_sel), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_write_sel(mem_write_sel), .mem_reg_write(mem_reg_write),
        .ex_opcode(ex_opcode), .ex_pc_next(ex_pc_next), .ex_br_taken(ex_br_taken),
        .imem_stall(imem_stall), .dmem_stall(dmem_stall), .wb_halt(wb_halt),
        .stall_fetch(stall_fetch), .stall_decode(stall_decode), .stall_ex(stall_ex),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex), .pc_sel(pc_sel),
        .epc(epc), .halted(halted)
    );

    typedef struct {
        bit [2:0]  rs, rt, ex_ws, mem_ws;
        bit        rs_vld, rt_vld, ex_rw, ex_mr, mem_rw;
        bit [4:0]  op;
        bit [15:0] pcn;
        bit        br, imem, dmem, halt, rst_n;
    } stim_t;

    typedef struct packed {
        logic        sf, sd, se, fi, fx;
        logic [1:0]  pc;
        logic [15:0] epc;
        logic        halted;
    } obs_t;

    typedef struct {
        obs_t  exp;
        string tag;
    } sb_t;

    sb_t q[$];
    int  checks = 0;
    int  errors = 0;

    // Reference model state: halted flag, remaining drain cycles, saved return PC.
    bit        m_halted;
    int        m_drain;
    bit [15:0] m_epc;

    function automatic bit reads(bit [2:0] src, bit vld, bit [2:0] dst, bit wen);
        return vld && wen && (src == dst);
    endfunction

    function automatic bit hazard(stim_t s);
        bit ex_dep, mem_dep;
        ex_dep  = reads(s.rs, s.rs_vld, s.ex_ws, s.ex_rw) || reads(s.rt, s.rt_vld, s.ex_ws, s.ex_rw);
        mem_dep = reads(s.rs, s.rs_vld, s.mem_ws, s.mem_rw) || reads(s.rt, s.rt_vld, s.mem_ws, s.mem_rw);
`ifdef PIPE_FWD_EN
        return ex_dep && s.ex_mr;
`else
        return ex_dep || mem_dep;
`endif
    endfunction

    function automatic obs_t model_out(stim_t s);
        obs_t o;
        o     = '0;
        o.epc = m_epc;
        if (m_halted || s.halt) begin
            o.sf = 1; o.halted = 1;
        end else if (s.dmem) begin
            o.sf = 1; o.sd = 1; o.se = 1;
        end else if (m_drain > 0) begin
            o.sf = 1;
        end else if (s.op == 5'd2) begin
            o.fi = 1; o.fx = 1; o.pc = 2'd2;
        end else if (s.op == 5'd3) begin
            o.fi = 1; o.fx = 1; o.pc = 2'd3;
        end else if (s.br) begin
            o.fi = 1; o.fx = 1; o.pc = 2'd1;
        end else if (hazard(s)) begin
            o.sf = 1; o.sd = 1;
        end else if (s.imem) begin
            o.sf = 1; o.fi = 1;
        end
        return o;
    endfunction

    task automatic model_reset();
        m_halted = 0;
        m_drain  = 0;
        m_epc    = '0;
    endtask

    task automatic model_step(stim_t s);
        if (!s.rst_n) model_reset();
        else if (m_halted || s.halt) m_halted = 1;
        else if (s.dmem) begin end
        else if (m_drain > 0) m_drain--;
        else if (s.op == 5'd2) begin
            m_epc   = s.pcn;
            m_drain = DRAIN;
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s       = '{default: 0};
        s.op    = 5'd1;
        s.rst_n = 1;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        int    r;
        s        = idle();
        s.rs     = 3'($urandom_range(7));
        s.rt     = 3'($urandom_range(7));
        s.ex_ws  = 3'($urandom_range(7));
        s.mem_ws = 3'($urandom_range(7));
        s.rs_vld = 1'($urandom_range(1));
        s.rt_vld = 1'($urandom_range(1));
        s.ex_rw  = 1'($urandom_range(1));
        s.ex_mr  = 1'($urandom_range(1));
        s.mem_rw = 1'($urandom_range(1));
        s.pcn    = 16'($urandom);
        r        = int'($urandom_range(99));
        if (r < 8) s.op = 5'd2;
        else if (r < 16) s.op = 5'd3;
        else begin
            s.op = 5'($urandom_range(31));
            if (s.op == 5'd2 || s.op == 5'd3) s.op = 5'd4;
        end
        s.br    = ($urandom_range(99) < 15);
        s.dmem  = ($urandom_range(99) < 12);
        s.imem  = ($urandom_range(99) < 20);
        s.halt  = ($urandom_range(999) < 3);
        s.rst_n = ($urandom_range(999) >= 10);
        return s;
    endfunction

    task automatic drive(stim_t s, string tag);
        sb_t e;
        @(posedge clk);
        #1;
        id_rs = s.rs; id_rt = s.rt; id_rs_vld = s.rs_vld; id_rt_vld = s.rt_vld;
        ex_write_sel = s.ex_ws; ex_reg_write = s.ex_rw; ex_mem_read = s.ex_mr;
        mem_write_sel = s.mem_ws; mem_reg_write = s.mem_rw;
        ex_opcode = s.op; ex_pc_next = s.pcn; ex_br_taken = s.br;
        imem_stall = s.imem; dmem_stall = s.dmem; wb_halt = s.halt;
        rst = s.rst_n;
        if (!s.rst_n) model_reset();
        e.exp = model_out(s);
        e.tag = tag;
        q.push_back(e);
        model_step(s);
    endtask

    // Monitor: every cycle carries a control word; compare away from the active edge.
    always @(negedge clk) begin
        sb_t  e;
        obs_t a;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = '{stall_fetch, stall_decode, stall_ex, flush_ifid, flush_idex, pc_sel, epc, halted};
            checks++;
            if (a !== e.exp) begin
                errors++;
                $display("FAIL %s: got sf%b sd%b se%b fi%b fx%b pc%b epc%h h%b, want sf%b sd%b se%b fi%b fx%b pc%b epc%h h%b",
                         e.tag, a.sf, a.sd, a.se, a.fi, a.fx, a.pc, a.epc, a.halted,
                         e.exp.sf, e.exp.sd, e.exp.se, e.exp.fi, e.exp.fx, e.exp.pc, e.exp.epc, e.exp.halted);
            end
        end
    end

    initial begin
        stim_t s;
        rst = 1'b0;
        {id_rs, id_rt, ex_write_sel, mem_write_sel} = '0;
        {id_rs_vld, id_rt_vld, ex_reg_write, ex_mem_read, mem_reg_write} = '0;
        ex_opcode = 5'd1; ex_pc_next = '0;
        {ex_br_taken, imem_stall, dmem_stall, wb_halt} = '0;
        model_reset();

        s = idle(); s.rst_n = 0;
        drive(s, "reset");
        drive(s, "reset");
        s = idle();
        drive(s, "idle_after_reset");

        s = idle(); s.ex_mr = 1; s.ex_rw = 1; s.ex_ws = 3; s.rs = 3; s.rs_vld = 1;
        drive(s, "load_use");
        drive(idle(), "load_use_release");

        s.br = 1;
        drive(s, "branch_beats_hazard");

        s = idle(); s.op = 5'd2; s.pcn = 16'h0040;
        drive(s, "siic_redirect");
        s.br = 1;
        drive(s, "exc_drain_ignores_siic");
        drive(idle(), "exc_drain_last");
        drive(idle(), "exc_exit");
        s = idle(); s.op = 5'd3;
        drive(s, "rti");

        s = idle(); s.op = 5'd2; s.pcn = 16'h1234;
        drive(s, "siic_again");
        s = idle(); s.dmem = 1;
        for (int i = 0; i < 3; i++) drive(s, "dmem_in_exc");
        for (int i = 0; i < 3; i++) drive(idle(), "exc_delayed_exit");

        s = idle(); s.mem_rw = 1; s.mem_ws = 5; s.rt = 5; s.rt_vld = 1;
        drive(s, "mem_stage_raw");
        s = idle(); s.imem = 1;
        drive(s, "imem_only");
        s = idle(); s.dmem = 1;
        drive(s, "memwait");
        s = idle(); s.op = 5'd2; s.pcn = 16'h00aa;
        drive(s, "siic_after_memwait");

        s = idle(); s.rst_n = 0;
        drive(s, "reset_mid_exc");
        drive(idle(), "run_after_reset");
        s = idle(); s.halt = 1;
        drive(s, "wb_halt");
        s = idle(); s.op = 5'd2; s.br = 1;
        for (int i = 0; i < 3; i++) drive(s, "halted_sticky");
        s = idle(); s.rst_n = 0;
        drive(s, "reset_leaves_halt");
        drive(idle(), "run_again");

        for (int i = 0; i < 4000; i++) drive(rand_stim(), "random");

        @(posedge clk);
        @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
